// File: rtl/cache_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : cache_mem_responder
// Description : Memory-side responder for data-cache misses. It owns the
//               backing storage array and serves one request at a time: a
//               single-word line fill (read) or a dirty-line write-back
//               (write). Each access completes a fixed LATENCY cycles after
//               acceptance, and the result is held until the cache takes it.
// Optional    : CACHE_MEM_ALIGN_CHECK_EN - when defined, a request whose
//               address is not word aligned is reported on resp_err_o, reads
//               return 0 and writes leave storage untouched. When undefined,
//               resp_err_o is 0 and address bits [1:0] are ignored.
// Ports       : clk_i, rst_i (async, active-high)
//               req_valid_i / req_ready_o / req_we_i / req_addr_i / req_wdata_i
//               resp_valid_o / resp_ready_i / resp_rdata_o / resp_err_o
// Revision    : 1.0 - initial release
// ============================================================================
module cache_mem_responder #(
  parameter int ADDRESS_WIDTH      = 32,
  parameter int DATA_WIDTH         = 32,
  parameter int USED_ADDRESS_WIDTH = 10,
  parameter int LATENCY            = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic                     req_we_i,
  input  logic [ADDRESS_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0]    req_wdata_i,
  output logic                     resp_valid_o,
  input  logic                     resp_ready_i,
  output logic [DATA_WIDTH-1:0]    resp_rdata_o,
  output logic                     resp_err_o
);

  localparam int         DEPTH    = 2 ** USED_ADDRESS_WIDTH;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e                        state_q, state_d;
  logic [3:0]                    cnt_q, cnt_d;
  logic                          we_q, we_d;
  logic [USED_ADDRESS_WIDTH-1:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0]         wdata_q, wdata_d;
  logic                          mis_q, mis_d;
  logic                          req_ready_q, req_ready_d;
  logic                          resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0]         resp_rdata_q, resp_rdata_d;
  logic                          resp_err_q, resp_err_d;

  logic [DATA_WIDTH-1:0]         mem_q [DEPTH];

  logic                          access;
  logic                          mem_we;
  logic                          req_misaligned;
  logic                          unused_addr_bits;

`ifdef CACHE_MEM_ALIGN_CHECK_EN
  assign req_misaligned = |req_addr_i[1:0];
`else
  assign req_misaligned = 1'b0;
`endif

  // Upper address bits alias onto the storage; byte-offset bits only matter
  // for the optional alignment check.
  assign unused_addr_bits = ^{req_addr_i[ADDRESS_WIDTH-1:USED_ADDRESS_WIDTH+2],
                              req_addr_i[1:0]};

  // The storage access happens on the edge that leaves WAIT.
  assign access = (state_q == ST_WAIT) && (cnt_q == 4'd0);
  assign mem_we = access && we_q && !mis_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    idx_d        = idx_q;
    wdata_d      = wdata_q;
    mis_d        = mis_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid_i && req_ready_q) begin
          we_d        = req_we_i;
          idx_d       = req_addr_i[USED_ADDRESS_WIDTH+1:2];
          wdata_d     = req_wdata_i;
          mis_d       = req_misaligned;
          cnt_d       = CNT_LOAD;
          req_ready_d = 1'b0;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          resp_valid_d = 1'b1;
          resp_err_d   = mis_q;
          // Writes and rejected (misaligned) requests return zero data.
          resp_rdata_d = (we_q || mis_q) ? '0 : mem_q[idx_q];
          state_d      = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (resp_ready_i) begin
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        resp_valid_d = 1'b0;
        req_ready_d  = 1'b1;
        state_d      = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      we_q         <= 1'b0;
      idx_q        <= '0;
      wdata_q      <= '0;
      mis_q        <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      idx_q        <= idx_d;
      wdata_q      <= wdata_d;
      mis_q        <= mis_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Storage is deliberately left out of reset; a reset during WAIT drops
  // state_q to IDLE, so mem_we never fires for the aborted write.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign req_ready_o  = req_ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;
  assign resp_err_o   = resp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_cache_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_mem_responder
// Description : Directed self-checking bench for cache_mem_responder with
//               default parameters (LATENCY=3, 1024-word storage).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_mem_responder;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic        resp_valid_o;
  logic        resp_ready_i = 1'b1;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;

  int checks   = 0;
  int failures = 0;

  cache_mem_responder dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_we_i     (req_we_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .resp_rdata_o (resp_rdata_o),
    .resp_err_o   (resp_err_o)
  );

  always #5 clk_i = ~clk_i;

  // Present a request, wait for acceptance and then for resp_valid_o.
  // lat = number of edges from the acceptance edge to resp_valid_o high.
  task automatic issue(input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, output int lat);
    int guard;
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_addr_i  = addr;
    req_wdata_i = wd;
    guard = 0;
    while (!req_ready_o && guard < 50) begin
      @(posedge clk_i); #1;
      guard++;
    end
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    lat = 0;
    do begin
      @(posedge clk_i); #1;
      lat++;
    end while (!resp_valid_o && lat < 20);
  endtask

  // One edge with resp_ready_i high completes the pending response.
  task automatic handshake();
    resp_ready_i = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    checks++; if (req_ready_o !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready_o); end
    checks++; if (resp_valid_o !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid_o); end
    checks++; if (resp_rdata_o !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=00000000", resp_rdata_o); end
    checks++; if (resp_err_o !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", resp_err_o); end
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    checks++; if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0) begin failures++; $display("FAIL post_reset_idle ready=%b valid=%b exp ready=1 valid=0", req_ready_o, resp_valid_o); end
  endtask

  task automatic test_write_read();
    int lat;
    issue(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, lat);
    checks++; if (lat != 3) begin failures++; $display("FAIL wr_latency got=%0d exp=3", lat); end
    checks++; if (resp_rdata_o !== 32'h0) begin failures++; $display("FAIL wr_rdata got=%h exp=00000000", resp_rdata_o); end
    checks++; if (resp_err_o !== 1'b0) begin failures++; $display("FAIL wr_err got=%b exp=0", resp_err_o); end
    handshake();
    checks++; if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0) begin failures++; $display("FAIL wr_return_idle ready=%b valid=%b exp ready=1 valid=0", req_ready_o, resp_valid_o); end
    issue(1'b0, 32'h0000_0010, 32'h0, lat);
    checks++; if (lat != 3) begin failures++; $display("FAIL rd_latency got=%0d exp=3", lat); end
    checks++; if (resp_rdata_o !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rd_data got=%h exp=deadbeef", resp_rdata_o); end
    handshake();
  endtask

  task automatic test_alias();
    int lat;
    issue(1'b1, 32'h0000_1004, 32'h1234_5678, lat);
    handshake();
    issue(1'b0, 32'h0000_0004, 32'h0, lat);
    checks++; if (resp_rdata_o !== 32'h1234_5678) begin failures++; $display("FAIL alias_data got=%h exp=12345678", resp_rdata_o); end
    handshake();
  endtask

  task automatic test_backpressure();
    int lat;
    issue(1'b1, 32'h0000_0030, 32'hCAFE_F00D, lat);
    handshake();
    resp_ready_i = 1'b0;
    issue(1'b0, 32'h0000_0030, 32'h0, lat);
    checks++; if (resp_valid_o !== 1'b1 || resp_rdata_o !== 32'hCAFE_F00D) begin failures++; $display("FAIL bp_first valid=%b data=%h exp valid=1 data=cafef00d", resp_valid_o, resp_rdata_o); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i); #1;
      checks++;
      if (resp_valid_o !== 1'b1 || resp_rdata_o !== 32'hCAFE_F00D || req_ready_o !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold cycle=%0d valid=%b data=%h ready=%b exp valid=1 data=cafef00d ready=0", i, resp_valid_o, resp_rdata_o, req_ready_o);
      end
    end
    handshake();
    checks++; if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0) begin failures++; $display("FAIL bp_release ready=%b valid=%b exp ready=1 valid=0", req_ready_o, resp_valid_o); end
  endtask

  task automatic test_reset_in_wait();
    int lat;
    int guard;
    issue(1'b1, 32'h0000_0020, 32'h1111_2222, lat);
    handshake();
    issue(1'b0, 32'h0000_0020, 32'h0, lat);
    checks++; if (resp_rdata_o !== 32'h1111_2222) begin failures++; $display("FAIL rw_prior got=%h exp=11112222", resp_rdata_o); end
    handshake();
    req_valid_i = 1'b1;
    req_we_i    = 1'b1;
    req_addr_i  = 32'h0000_0020;
    req_wdata_i = 32'hAAAA_5555;
    guard = 0;
    while (!req_ready_o && guard < 50) begin
      @(posedge clk_i); #1;
      guard++;
    end
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    checks++; if (req_ready_o !== 1'b0) begin failures++; $display("FAIL rw_in_wait ready=%b exp=0", req_ready_o); end
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    #1;
    checks++;
    if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0 || resp_rdata_o !== 32'h0 || resp_err_o !== 1'b0) begin
      failures++;
      $display("FAIL rw_reset_values ready=%b valid=%b data=%h err=%b exp 1 0 00000000 0", req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o);
    end
    repeat (4) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    issue(1'b0, 32'h0000_0020, 32'h0, lat);
    checks++; if (resp_rdata_o !== 32'h1111_2222) begin failures++; $display("FAIL rw_not_committed got=%h exp=11112222", resp_rdata_o); end
    handshake();
  endtask

  task automatic test_back_to_back();
    int          n_acc, n_hs, acc1, acc2, hs1;
    logic        pr, pv, overlap;
    logic [31:0] prd, d1, d2;
    n_acc = 0; n_hs = 0; acc1 = 0; acc2 = 0; hs1 = 0;
    overlap = 1'b0; d1 = '0; d2 = '0;
    resp_ready_i = 1'b1;
    req_we_i     = 1'b0;
    req_addr_i   = 32'h0000_0010;
    req_valid_i  = 1'b1;
    pr  = req_ready_o;
    pv  = resp_valid_o;
    prd = resp_rdata_o;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(posedge clk_i); #1;
      if (pr && req_valid_i) begin
        n_acc++;
        if (n_acc == 1) begin acc1 = cyc; req_addr_i = 32'h0000_1004; end
        else begin acc2 = cyc; req_valid_i = 1'b0; end
      end
      if (pv) begin
        n_hs++;
        if (n_hs == 1) begin hs1 = cyc; d1 = prd; end
        else if (n_hs == 2) d2 = prd;
      end
      if (req_ready_o && resp_valid_o) overlap = 1'b1;
      pr  = req_ready_o;
      pv  = resp_valid_o;
      prd = resp_rdata_o;
    end
    checks++; if (n_acc != 2 || n_hs != 2) begin failures++; $display("FAIL b2b_counts acc=%0d hs=%0d exp 2 2", n_acc, n_hs); end
    checks++; if (acc2 - acc1 != 5) begin failures++; $display("FAIL b2b_spacing got=%0d exp=5", acc2 - acc1); end
    checks++; if (acc2 != hs1 + 1) begin failures++; $display("FAIL b2b_after_hs acc2=%0d hs1=%0d exp acc2=hs1+1", acc2, hs1); end
    checks++; if (overlap !== 1'b0) begin failures++; $display("FAIL b2b_overlap got=%b exp=0", overlap); end
    checks++; if (d1 !== 32'hDEAD_BEEF || d2 !== 32'h1234_5678) begin failures++; $display("FAIL b2b_data got=%h,%h exp=deadbeef,12345678", d1, d2); end
  endtask

  task automatic test_misalign();
    int          lat;
    logic        exp_err;
    logic [31:0] exp_word;
`ifdef CACHE_MEM_ALIGN_CHECK_EN
    exp_err  = 1'b1;
    exp_word = 32'h0000_1111;
`else
    exp_err  = 1'b0;
    exp_word = 32'hFFFF_FFFF;
`endif
    issue(1'b1, 32'h0000_0020, 32'h0000_1111, lat);
    handshake();
    issue(1'b1, 32'h0000_0022, 32'hFFFF_FFFF, lat);
    checks++; if (resp_err_o !== exp_err) begin failures++; $display("FAIL mis_err got=%b exp=%b", resp_err_o, exp_err); end
    checks++; if (resp_rdata_o !== 32'h0) begin failures++; $display("FAIL mis_rdata got=%h exp=00000000", resp_rdata_o); end
    handshake();
    issue(1'b0, 32'h0000_0020, 32'h0, lat);
    checks++; if (resp_rdata_o !== exp_word) begin failures++; $display("FAIL mis_word got=%h exp=%h", resp_rdata_o, exp_word); end
    checks++; if (resp_err_o !== 1'b0) begin failures++; $display("FAIL mis_aligned_err got=%b exp=0", resp_err_o); end
    handshake();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_alias();
    test_backpressure();
    test_reset_in_wait();
    test_back_to_back();
    test_misalign();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
